// File: rtl/m650_nconv_multi.sv
// Per-channel AND/NAND output converter with optional inertial-delay slew filter.
// Latency 1 clk direct, SLEW_CYCLES clks slewed; no backpressure, outputs are free-running.
module m650_nconv_multi #(
    parameter int                    CHANNELS    = 3,
    parameter int                    FANIN       = 3,
    parameter int                    SLEW_CYCLES = 4,
    parameter logic [CHANNELS-1:0]   INV_MASK    = '0,
    parameter int                    CNT_W       = $clog2(SLEW_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*FANIN-1:0] in_bus,
    input  logic [CHANNELS-1:0]       slew_en,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLEW_CYCLES - 1);

    logic [CHANNELS-1:0] target;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [CNT_W-1:0] cnt;

        assign target[c] = (&in_bus[c*FANIN +: FANIN]) ^ INV_MASK[c];
        assign busy[c]   = (cnt != '0);

        // A mismatch must persist for SLEW_CYCLES edges; any agreement clears the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                out[c] <= 1'b0;
                cnt    <= '0;
            end else if (target[c] == out[c]) begin
                cnt    <= '0;
            end else if (!slew_en[c]) begin
                out[c] <= target[c];
                cnt    <= '0;
            end else if (cnt == CNT_LAST) begin
                out[c] <= target[c];
                cnt    <= '0;
            end else begin
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule
